// File: rtl/div_restoring_radix_2_if.sv
// Operand/result handshake bundle for the restoring divider.
// Slave is the divider, master drives operands and consumes results.
interface div_restoring_radix_2_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0] r;
  logic                  div_by_zero;

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, q, r, div_by_zero
  );

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, q, r, div_by_zero
  );
endinterface

// File: rtl/div_restoring_radix_2.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Result registers load only on the final iteration and are held until the next one.
module div_restoring_radix_2 #(
  parameter int DATA_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  div_restoring_radix_2_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        r_state, w_next;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_div;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_r;
  logic          r_dbz;

  logic          w_accept;
  logic [W:0]    w_shift;
  logic [W:0]    w_trial;
  logic          w_ge;
  logic [W-1:0]  w_rem_nxt;
  logic [W-1:0]  w_quo_nxt;

  assign w_accept = (r_state == IDLE) && bus.in_valid;

  // The restored remainder is always below the divisor, so W bits hold it;
  // the shift and trial subtract still run at W+1 bits.
  assign w_shift   = {r_rem, r_quo[W-1]};
  assign w_trial   = w_shift - {1'b0, r_div};
  assign w_ge      = ~w_trial[W];
  assign w_rem_nxt = w_ge ? w_trial[W-1:0] : w_shift[W-1:0];
  assign w_quo_nxt = {r_quo[W-2:0], w_ge};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)      w_next = CALC;
      CALC:    if (r_cnt == LAST)     w_next = DONE;
      DONE:    if (bus.out_ready)     w_next = IDLE;
      default:                        w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_rem <= '0;
      r_quo <= bus.A;
      r_div <= bus.B;
      r_cnt <= '0;
      r_dbz <= (bus.B == '0);
    end else if (r_state == CALC) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST) begin
        r_q <= w_quo_nxt;
        r_r <= w_rem_nxt;
      end
    end
  end

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = (r_state == DONE);
  assign bus.q           = r_q;
  assign bus.r           = r_r;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: doc/div_restoring_radix_2.md
Name: div_restoring_radix_2

Overview:
- Sequential unsigned restoring divider, radix 2: one quotient bit per clock.
- Inverse-arithmetic companion to the combinational multiplier blocks in the mult/div arithmetic library.
- Accepts an operand pair over a valid/ready handshake and returns quotient and remainder over a second valid/ready handshake.
- Intended for datapaths that need divide at low area and can tolerate DATA_WIDTH-cycle latency.

Parameters:
- DATA_WIDTH, 4, width of dividend, divisor, quotient and remainder; any value >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair A/B is valid.
- in_ready  output  1  block can accept operands.
- A  input  DATA_WIDTH  unsigned dividend.
- B  input  DATA_WIDTH  unsigned divisor.
- out_valid  output  1  q/r/div_by_zero are valid.
- out_ready  input  1  consumer accepts the result.
- q  output  DATA_WIDTH  quotient, floor(A/B).
- r  output  DATA_WIDTH  remainder, A - q*B.
- div_by_zero  output  1  result was produced with B == 0.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE; in_ready=1; out_valid=0; q, r and div_by_zero = 0; iteration counter = 0.
- States and transitions:
  - IDLE: in_ready=1. Accept when in_valid & in_ready at a rising edge. Register A into the quotient/shift register, B into the divisor register, clear the partial remainder (DATA_WIDTH+1 bits), counter=0, go to CALC. div_by_zero is registered as (B==0).
  - CALC: in_ready=0, out_valid=0. Each cycle:
    - shift {partial remainder, quotient register} left by 1;
    - compute trial = partial remainder - {1'b0, divisor} at DATA_WIDTH+1 bits;
    - if trial is non-negative (MSB 0), partial remainder = trial and quotient LSB = 1; otherwise restore (keep the shifted value) and quotient LSB = 0;
    - counter increments; after the iteration with counter == DATA_WIDTH-1, go to DONE.
  - DONE: out_valid=1. q is the quotient register; r is the low DATA_WIDTH bits of the partial remainder. When out_ready=1 at an edge, the result transfers and the block returns to IDLE.
- Latency: out_valid first high on the DATA_WIDTH-th rising edge after the accepting edge (for example, 4 cycles at DATA_WIDTH=4). Throughput is one result per DATA_WIDTH+2 cycles at best.
- No same-cycle accept after a transfer: in_ready rises the cycle after the DONE->IDLE transition.
- Backpressure: while in DONE with out_ready=0, q, r, div_by_zero and out_valid hold stable indefinitely.
- in_valid and A/B are ignored outside IDLE. Operands are sampled only on the accept edge, so later changes to A/B have no effect.
- out_ready is ignored outside DONE.
- Divide by zero: no special datapath. The algorithm naturally yields q = all ones and r = A, with div_by_zero=1. Latency is unchanged.
- A < B gives q=0, r=A. A == B gives q=1, r=0 (B != 0).
- Reset asserted in any state, including mid-CALC or DONE with a pending result, returns to reset values at that edge. A partial or unconsumed result is discarded.
- q, r and div_by_zero change only on the accept edge (div_by_zero) and in CALC/DONE transitions. They are cleared only by reset.

Test Plan:
- DATA_WIDTH=4, A=13, B=4, out_ready=1 -> out_valid on the 4th edge after accept; q=3, r=1, div_by_zero=0; in_ready returns 1 one cycle after the transfer.
- DATA_WIDTH=4, A=7, B=0 -> q=15, r=7, div_by_zero=1, same latency. Then A=15, B=1 -> q=15, r=0, div_by_zero=0. Then A=3, B=9 -> q=0, r=3.
- Backpressure: A=9, B=2 with out_ready=0 for 6 cycles after out_valid; toggle in_valid and A/B meanwhile -> q=4, r=1 stay stable, in_ready=0, nothing new is accepted; releasing out_ready completes exactly one transfer.
- Reset mid-CALC: accept A=14, B=3, assert rst on the 2nd CALC cycle -> next cycle in_ready=1, out_valid=0, q=r=0. The next operation, A=14, B=3, yields q=4, r=2.
- DATA_WIDTH=8, A=200, B=7 -> q=28, r=4 at 8-cycle latency. Follow with 1000 random back-to-back pairs checked against a q=A/B, r=A%B model, including B=0, B=1, A=255 and B=255.
